// File: rtl/pcs_tx_oset_fsm.sv
// pcs_tx_oset_fsm: 1000BASE-X PCS transmit ordered-set state machine.
// Converts GMII TX_EN/TX_ER/TXD into ordered-set codes for the code-group encoder.
// Handles xmit modes, carrier extension, EPD alignment and a saturating error count.
//
// Ports:
//   CLK              clock, all state changes on rising edge
//   RESET            synchronous active-low reset
//   TXD[7:0]         GMII transmit data
//   TX_EN, TX_ER     GMII transmit enable / error
//   TX_OSET_indicate code-group process done with current set; FSM may advance
//   tx_even          1 = current code-group is even (used at EPD2 only)
//   xmit[1:0]        00 CONFIGURATION, 01 IDLE, 10 DATA, 11 treated as IDLE
//   tx_o_set[2:0]    0 /I/, 1 /C/, 2 /S/, 3 /D/, 4 /T/, 5 /R/, 6 /V/
//   tx_data[7:0]     octet for /D/, 0 otherwise
//   transmitting     high from /S/ (or start /V/) through last /D/ or /V/
//   tx_err_cnt       saturating count of /V/ sets emitted
module pcs_tx_oset_fsm #(
  parameter bit          EXT_EN     = 1'b1,
  parameter bit          EPD3_ALIGN = 1'b1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [7:0]       TXD,
  input  logic             TX_EN,
  input  logic             TX_ER,
  input  logic             TX_OSET_indicate,
  input  logic             tx_even,
  input  logic [1:0]       xmit,
  output logic [2:0]       tx_o_set,
  output logic [7:0]       tx_data,
  output logic             transmitting,
  output logic [CNT_W-1:0] tx_err_cnt
);

  localparam logic [1:0] XMIT_CFG  = 2'b00;
  localparam logic [1:0] XMIT_DATA = 2'b10;

  localparam logic [2:0] OS_I = 3'd0;
  localparam logic [2:0] OS_C = 3'd1;
  localparam logic [2:0] OS_S = 3'd2;
  localparam logic [2:0] OS_D = 3'd3;
  localparam logic [2:0] OS_T = 3'd4;
  localparam logic [2:0] OS_R = 3'd5;
  localparam logic [2:0] OS_V = 3'd6;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [3:0] {
    ST_XMIT_IDLE,
    ST_CONFIG,
    ST_SOP,
    ST_START_ERR,
    ST_PACKET,
    ST_EOP,
    ST_EOP_EXT,
    ST_EXTEND,
    ST_EPD2,
    ST_EPD3
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       oset_q, oset_d;
  logic [7:0]       data_q, data_d;
  logic             tx_q, tx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_set;

  // Next state and next registered outputs; everything holds without indicate.
  always_comb begin
    state_d = state_q;
    oset_d  = oset_q;
    data_d  = data_q;
    tx_d    = tx_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;

    if (TX_OSET_indicate) begin
      if (xmit == XMIT_CFG) begin
        state_d = ST_CONFIG;
      end else begin
        case (state_q)
          ST_XMIT_IDLE: begin
            if (xmit == XMIT_DATA && TX_EN) begin
              state_d = TX_ER ? ST_START_ERR : ST_SOP;
              err_set = TX_ER;
            end
          end
          // The set following /S/ or a start /V/ already follows the packet rules.
          ST_SOP, ST_START_ERR, ST_PACKET: begin
            if (TX_EN) begin
              state_d = ST_PACKET;
              err_set = TX_ER;
            end else if (TX_ER && EXT_EN) begin
              state_d = ST_EOP_EXT;
            end else begin
              state_d = ST_EOP;
            end
          end
          ST_EOP:     state_d = ST_EPD2;
          ST_EOP_EXT: state_d = ST_EXTEND;
          ST_EXTEND: begin
            if (TX_EN || !TX_ER) state_d = ST_EPD2;
          end
          ST_EPD2:   state_d = (tx_even && EPD3_ALIGN) ? ST_EPD3 : ST_XMIT_IDLE;
          ST_EPD3:   state_d = ST_XMIT_IDLE;
          ST_CONFIG: state_d = ST_XMIT_IDLE;
          default:   state_d = ST_XMIT_IDLE;
        endcase
      end

      // Output code follows the state being entered.
      data_d = 8'h00;
      case (state_d)
        ST_XMIT_IDLE: oset_d = OS_I;
        ST_CONFIG:    oset_d = OS_C;
        ST_SOP:       oset_d = OS_S;
        ST_START_ERR: oset_d = OS_V;
        ST_PACKET: begin
          oset_d = TX_ER ? OS_V : OS_D;
          if (!TX_ER) data_d = TXD;
        end
        ST_EOP, ST_EOP_EXT: oset_d = OS_T;
        default:            oset_d = OS_R;
      endcase

      tx_d = (state_d == ST_SOP) || (state_d == ST_START_ERR) || (state_d == ST_PACKET);

      if (err_set && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_XMIT_IDLE;
      oset_q  <= OS_I;
      data_q  <= 8'h00;
      tx_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      oset_q  <= oset_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tx_o_set     = oset_q;
  assign tx_data      = data_q;
  assign transmitting = tx_q;
  assign tx_err_cnt   = cnt_q;

endmodule
